fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with single outstanding request and IF/ID register
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pc_out                   current fetch PC to the next-PC calculator
//   npc_in                   next PC, sampled on accept or flush
//   stall, flush             pipeline control (flush has priority)
//   imem_req, imem_addr      instruction memory request / word address
//   imem_ack, imem_rdata     single-cycle response strobe / instruction word
//   if_valid, if_instr,
//   if_pc, if_adel           registered IF/ID payload

module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] pc_out,
    input  logic [31:0] npc_in,
    input  logic        stall,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        if_adel
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [31:0] buf_word;
    logic        buf_adel;

    logic        misaligned;
    logic        fetch_done;
    logic [31:0] fetch_word;
    logic        fetch_adel;

    assign misaligned = (req_addr[1:0] != 2'b00);
    assign pc_out     = pc;
    assign imem_addr  = req_addr;
    // A misaligned fetch never reaches memory; it completes internally.
    assign imem_req   = !rst && (((state == FETCH) && !misaligned) || (state == DRAIN));

    always_comb begin
        fetch_done = 1'b0;
        fetch_word = imem_rdata;
        fetch_adel = 1'b0;
        if (state == FETCH) begin
            if (misaligned) begin
                fetch_done = 1'b1;
                fetch_word = NOP_WORD;
                fetch_adel = 1'b1;
            end else begin
                fetch_done = imem_ack;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            buf_word <= 32'h0;
            buf_adel <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= 32'h0;
            if_pc    <= 32'h0;
            if_adel  <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (flush) begin
                        if_valid <= 1'b0;
                        pc       <= npc_in;
                        if (fetch_done) begin
                            req_addr <= npc_in;
                        end else begin
                            // Request already on the bus: keep it stable, drop its reply later.
                            state <= DRAIN;
                        end
                    end else if (fetch_done) begin
                        if (!stall) begin
                            if_valid <= 1'b1;
                            if_instr <= fetch_word;
                            if_pc    <= req_addr;
                            if_adel  <= fetch_adel;
                            pc       <= npc_in;
                            req_addr <= npc_in;
                        end else begin
                            buf_word <= fetch_word;
                            buf_adel <= fetch_adel;
                            state    <= HOLD;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        if_valid <= 1'b0;
                        pc       <= npc_in;
                        req_addr <= npc_in;
                        state    <= FETCH;
                    end else if (!stall) begin
                        if_valid <= 1'b1;
                        if_instr <= buf_word;
                        if_pc    <= req_addr;
                        if_adel  <= buf_adel;
                        pc       <= npc_in;
                        req_addr <= npc_in;
                        state    <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_ack) begin
                        state <= FETCH;
                        if (flush) begin
                            pc       <= npc_in;
                            req_addr <= npc_in;
                        end else begin
                            req_addr <= pc;
                        end
                    end else if (flush) begin
                        pc <= npc_in;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit against a transaction model

module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_out;
    logic [31:0] npc_in;
    logic        stall;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_adel;

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) dut (
        .clk(clk), .rst(rst), .pc_out(pc_out), .npc_in(npc_in),
        .stall(stall), .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .if_valid(if_valid),
        .if_instr(if_instr), .if_pc(if_pc), .if_adel(if_adel)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0123_4567;
    endfunction

    // Transaction-level reference: the request in flight (address and
    // whether it has been killed), words parked under stall, and the IF/ID view.
    typedef struct {
        logic [31:0] word;
        logic        adel;
    } parked_t;

    parked_t     parked[$];
    logic [31:0] m_pc, m_req;
    bit          m_killed, m_rst;
    logic        m_v, m_adel;
    logic [31:0] m_instr, m_ipc;

    function automatic bit exp_req();
        return !m_rst && parked.size() == 0 && (m_killed || m_req[1:0] == 2'b00);
    endfunction

    task automatic model_reset();
        m_pc = RESET_PC; m_req = RESET_PC; m_killed = 0; parked.delete();
        m_v = 0; m_instr = 0; m_ipc = 0; m_adel = 0;
    endtask

    task automatic deliver(input logic [31:0] w, input logic ad, input logic [31:0] at);
        m_v = 1; m_instr = w; m_adel = ad; m_ipc = at;
    endtask

    task automatic model_cycle(input bit a, input bit s, input bit f, input logic [31:0] n,
                               input logic [31:0] rd);
        parked_t p;
        bit got;
        if (parked.size() != 0) begin
            if (f) begin
                parked.delete(); m_v = 0; m_pc = n; m_req = n;
            end else if (!s) begin
                p = parked.pop_front();
                deliver(p.word, p.adel, m_req);
                m_pc = n; m_req = n;
            end
        end else if (m_killed) begin
            if (a) begin
                m_killed = 0;
                m_req = f ? n : m_pc;
                if (f) m_pc = n;
            end else if (f) begin
                m_pc = n;
            end
        end else begin
            got = a || (m_req[1:0] != 2'b00);
            p.adel = (m_req[1:0] != 2'b00);
            p.word = p.adel ? NOP_WORD : rd;
            if (f) begin
                m_v = 0; m_pc = n;
                if (got) m_req = n; else m_killed = 1;
            end else if (got) begin
                if (!s) begin
                    deliver(p.word, p.adel, m_req);
                    m_pc = n; m_req = n;
                end else begin
                    parked.push_back(p);
                end
            end else if (!s) begin
                m_v = 0;
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".pc_out"},   pc_out, m_pc);
        check({ph, ".imem_req"}, 32'(imem_req), 32'(exp_req()));
        check({ph, ".imem_addr"}, imem_addr, m_req);
        check({ph, ".if_valid"}, 32'(if_valid), 32'(m_v));
        check({ph, ".if_instr"}, if_instr, m_instr);
        check({ph, ".if_pc"},    if_pc, m_ipc);
        check({ph, ".if_adel"},  32'(if_adel), 32'(m_adel));
    endtask

    // One clock: inputs at negedge, model advanced, outputs compared after the edge.
    task automatic step(input string ph, input bit a, input bit s, input bit f,
                        input logic [31:0] n, input bit use_w, input logic [31:0] w);
        @(negedge clk);
        imem_ack   = a && exp_req();
        imem_rdata = imem_ack ? (use_w ? w : mem(m_req)) : $urandom;
        stall      = s;
        flush      = f;
        npc_in     = n;
        model_cycle(imem_ack, s, f, n, imem_rdata);
        @(posedge clk);
        #1;
        check_outputs(ph);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; m_rst = 1;
        model_reset();
        #1;
        check_outputs("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            imem_ack = $urandom_range(0, 1);   // stray acks must be ignored in reset
            imem_rdata = $urandom;
            @(posedge clk); #1;
            check_outputs("rst_hold");
        end
        @(negedge clk);
        rst = 0; m_rst = 0; imem_ack = 0; stall = 0; flush = 0;
    endtask

    function automatic logic [31:0] pick_npc();
        int r = $urandom_range(0, 9);
        if (r <= 5) return m_pc + 32'd4;
        if (r == 6) return {$urandom} & 32'hFFFF_FFFC;
        if (r == 7) return m_pc + 32'd2;
        if (r == 8) return 32'hFFFF_FFFC;
        return 32'h0;
    endfunction

    initial begin
        rst = 1; m_rst = 1; stall = 0; flush = 0; imem_ack = 0; imem_rdata = 0; npc_in = 0;
        model_reset();
        do_reset();

        // Reset release then three back-to-back accepts.
        #1;
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RESET_PC);
        for (int i = 0; i < 3; i++) begin
            step("seq", 1, 0, 0, m_pc + 32'd4, 0, 0);
            check("seq_pc", if_pc, 32'h3000 + 32'(4 * i));
            check("seq_valid", 32'(if_valid), 32'd1);
        end

        // Delayed ack: request at 0x300C held while if_valid drops.
        for (int i = 0; i < 3; i++) begin
            step("wait", 0, 0, 0, 32'hDEAD_BEE0, 0, 0);
            check("wait_addr", imem_addr, 32'h300C);
            check("wait_valid", 32'(if_valid), 32'd0);
        end
        step("wait_ack", 1, 0, 0, m_pc + 32'd4, 0, 0);

        // Stall while the word arrives, then release.
        step("stall_ack", 1, 1, 0, 32'h1111_1110, 1, 32'h2108_0001);
        step("stall_hold", 0, 1, 0, 32'h2222_2220, 0, 0);
        check("hold_req", 32'(imem_req), 32'd0);
        step("stall_rel", 0, 0, 0, 32'h3010, 0, 0);
        check("rel_instr", if_instr, 32'h2108_0001);
        check("rel_valid", 32'(if_valid), 32'd1);

        // Flush while the request to 0x3010 is pending.
        step("flush", 0, 0, 1, 32'h4180, 0, 0);
        check("flush_addr", imem_addr, 32'h3010);
        check("flush_pc", pc_out, 32'h4180);
        step("drain_ack", 1, 0, 0, 32'h9990, 0, 0);
        check("drain_addr", imem_addr, 32'h4180);
        check("drain_valid", 32'(if_valid), 32'd0);
        step("after_drain", 1, 0, 0, 32'h3002, 0, 0);
        check("after_pc", if_pc, 32'h4180);

        // Misaligned target completes internally.
        check("adel_req", 32'(imem_req), 32'd0);
        step("adel", 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        check("adel_flag", 32'(if_adel), 32'd1);
        check("adel_instr", if_instr, NOP_WORD);
        check("adel_pc", if_pc, 32'h3002);

        // Address wrap, then stall+flush together in HOLD.
        step("wrap", 1, 0, 0, 32'h0, 0, 0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        step("hold_in", 1, 1, 0, 32'h7770, 0, 0);
        step("hold_flush", 0, 1, 1, 32'h5000, 0, 0);
        check("hf_valid", 32'(if_valid), 32'd0);
        check("hf_addr", imem_addr, 32'h5000);
        check("hf_req", 32'(imem_req), 32'd1);

        // Random traffic with occasional mid-request resets.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            step("rnd", $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 8, pick_npc(), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
